// File: rtl/cache_fill_fsm.sv
// Cache miss fill sequencer: issues the block's word reads and steers returned words into the data array.
// Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missed word and wraps within the block.
module cache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_address
);
    localparam int unsigned OFF_W   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W   = OFF_W + 1;
    localparam int unsigned BLK_LSB = OFF_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:BLK_LSB]   base_q, base_d;
    logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]          recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic                      busy_q, busy_d;
    logic [OFF_W-1:0]          first_word;
    logic [OFF_W-1:0]          miss_first;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0]          start_q, start_d;
    assign first_word = start_q;
    assign miss_first = miss_address[OFF_W:1];
    logic unused_miss_bits;
    assign unused_miss_bits = miss_address[0];
`else
    assign first_word = '0;
    assign miss_first = '0;
    logic unused_miss_bits;
    assign unused_miss_bits = ^miss_address[BLK_LSB-1:0];
`endif

    // Offset arithmetic is OFF_W bits wide so the walk wraps within the block.
    function automatic logic [OFF_W-1:0] word_of(input logic [OFF_W-1:0] first,
                                                 input logic [CNT_W-1:0] n);
        return first + n[OFF_W-1:0];
    endfunction

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        mem_addr_d       = mem_addr_q;
        busy_d           = busy_q;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        start_d          = start_q;
`endif
        mem_req          = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = '0;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d     = FILL;
                    busy_d      = 1'b1;
                    base_d      = miss_address[ADDR_W-1:BLK_LSB];
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                    start_d     = miss_first;
`endif
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    mem_addr_d  = {miss_address[ADDR_W-1:BLK_LSB], miss_first, 1'b0};
                end
            end
            FILL: begin
                // memory_address is registered, so the next request address is prepared a cycle early.
                if (issue_cnt_q != CNT_FULL) begin
                    mem_req     = 1'b1;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q != CNT_LAST) begin
                        mem_addr_d = {base_q, word_of(first_word, issue_cnt_q + CNT_W'(1)), 1'b0};
                    end
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_address     = {base_q, word_of(first_word, recv_cnt_q), 1'b0};
                    recv_cnt_d       = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_q == CNT_LAST) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                        busy_d          = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start_q     <= start_d;
`endif
        end
    end

    assign fsm_busy       = busy_q;
    assign memory_address = mem_addr_q;

endmodule
